// File: rtl/keypad_scanner.sv
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad (Pmod KYPD style). One column is
// driven low at a time for SCAN_DIV cycles. The rows are sampled at the
// end of each column's dwell and assembled into a 16-bit snapshot of
// pressed keys. A full snapshot must repeat for DEBOUNCE_SCANS scans in a
// row before it is accepted. A lone accepted key produces a one-cycle
// event.
//
// Parameters:
//   SCAN_DIV        clock cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS  identical full scans required to accept a snapshot (>= 1)
//
// Ports:
//   clock      system clock, rising edge
//   reset_n    asynchronous active-low reset
//   row[3:0]   keypad rows, active-low, asynchronous to clock
//   col[3:0]   keypad columns, active-low one-hot
//   key_code   {column[1:0], row[1:0]} of the last accepted key
//   key_valid  one-cycle pulse for each newly accepted single key press
//   key_held   high while the accepted key is still pressed
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE_SCANS);
  localparam logic [STB_W-1:0] STB_ONE = STB_W'(1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HELD = 1'b1;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [CNT_W-1:0] dwell_cnt;
  logic [1:0]       col_idx;
  logic [15:0]      snapshot;
  logic [15:0]      prev_snapshot;
  logic [15:0]      accepted;
  logic [STB_W-1:0] stable_cnt;
  logic             eval_pending;
  logic [0:0]       state;

  logic             capture;
  logic             scan_done;
  logic [15:0]      scan_full;
  logic             snap_equal;
  logic [STB_W-1:0] next_stable;
  logic             accept_now;
  logic             single_key;
  logic [3:0]       key_pos;

  // Two-flop synchronizer on the asynchronous rows. Idle rows read as
  // all-high, so the flops reset to 1 to avoid phantom presses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // The last column of a scan is combined with the captured first three
  // columns, so the completed snapshot is available on the capture cycle
  // itself. The "first reaches" test keeps a saturated count from
  // re-accepting the same snapshot every scan.
  always_comb begin
    capture    = (dwell_cnt == CNT_MAX);
    scan_done  = capture && (col_idx == 2'd3);
    scan_full  = {~row_sync, snapshot[11:0]};
    snap_equal = (scan_full == prev_snapshot);
    if (!snap_equal) begin
      next_stable = STB_ONE;
    end else if (stable_cnt == STB_MAX) begin
      next_stable = stable_cnt;
    end else begin
      next_stable = stable_cnt + STB_ONE;
    end
    accept_now = scan_done && (next_stable == STB_MAX) &&
                 !(snap_equal && (stable_cnt == STB_MAX));
  end

  // Column dwell timer and rotation. The rows are captured on the last
  // dwell cycle, and the column advances on the same edge. The new column
  // is therefore driven from the following cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
      col       <= 4'b1110;
      snapshot  <= '0;
    end else if (capture) begin
      dwell_cnt                 <= '0;
      col_idx                   <= col_idx + 2'd1;
      col                       <= {col[2:0], col[3]};
      snapshot[col_idx*4 +: 4]  <= ~row_sync;
    end else begin
      dwell_cnt <= dwell_cnt + CNT_ONE;
    end
  end

  // Debounce history. A snapshot becomes accepted only after it has
  // repeated for enough consecutive scans. The FSM then gets one
  // evaluation strobe on the next cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_snapshot <= '0;
      stable_cnt    <= '0;
      accepted      <= '0;
      eval_pending  <= 1'b0;
    end else begin
      eval_pending <= accept_now;
      if (scan_done) begin
        prev_snapshot <= scan_full;
        stable_cnt    <= next_stable;
      end
      if (accept_now) begin
        accepted <= scan_full;
      end
    end
  end

  // Exactly-one-key detection and encoding. The bit index already equals
  // {column, row}.
  always_comb begin
    single_key = (accepted != 16'd0) &&
                 ((accepted & (accepted - 16'd1)) == 16'd0);
    key_pos = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (accepted[i]) begin
        key_pos = 4'(i);
      end
    end
  end

  // Press/release FSM. Once a key is held, any nonzero accepted snapshot
  // keeps the FSM in HELD. A new event therefore always needs a full
  // release first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (eval_pending) begin
        case (state)
          IDLE: begin
            if (single_key) begin
              key_code  <= key_pos;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= HELD;
            end
          end
          default: begin
            if (accepted == 16'd0) begin
              key_held <= 1'b0;
              state    <= IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//
// Directed bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_SCANS=2.
// A small keypad model pulls a row low whenever a pressed key's column is
// driven. The bench applies a table of key-state phases and checks the
// event count, code, held flag and settling time of each phase. Reset,
// column rotation, bounce and reset-while-held are hand-written sequences.
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int SCAN_CYCLES    = 4 * SCAN_DIV;
  localparam int SETTLE_LIMIT   = 48;

  logic       clock;
  logic       reset_n;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;

  int checks;
  int errors;

  typedef struct {
    logic [15:0] keys;
    int          cycles;
    int          exp_pulses;
    logic [3:0]  exp_code;
    logic        exp_held;
  } phase_t;

  phase_t phases [10];

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad matrix model: a pressed key shorts its row to its column, so the
  // row reads low while that column is driven low.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4 + r] && !col[c]) begin
          row[r] = 1'b0;
        end
      end
    end
  end

  task automatic check_output(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  // Hold one key state for a phase. The bench watches pulses, the held
  // flag settling and the column encoding, then checks the end state.
  task automatic apply_stimulus(input phase_t ph, input int idx);
    int pulses;
    int last_mismatch;
    int col_bad;
    pressed       = ph.keys;
    pulses        = 0;
    last_mismatch = -1;
    col_bad       = 0;
    for (int i = 0; i < ph.cycles; i++) begin
      @(posedge clock);
      #1;
      if (key_valid) pulses++;
      if (key_held !== ph.exp_held) last_mismatch = i;
      if ($countones(~col) != 1) col_bad = 1;
    end
    check_output($sformatf("phase%0d_pulses", idx), pulses, ph.exp_pulses);
    check_output($sformatf("phase%0d_code", idx), int'(key_code), int'(ph.exp_code));
    check_output($sformatf("phase%0d_held", idx), int'(key_held), int'(ph.exp_held));
    check_output($sformatf("phase%0d_settled", idx),
                 int'(last_mismatch < SETTLE_LIMIT), 1);
    check_output($sformatf("phase%0d_col_onecold", idx), col_bad, 0);
  endtask

  // Bounded wait for a column value.
  task automatic wait_col(input logic [3:0] value, output int found);
    found = 0;
    for (int i = 0; i < 4 * SCAN_CYCLES; i++) begin
      @(posedge clock);
      #1;
      if (col == value) begin
        found = 1;
        break;
      end
    end
  endtask

  // A press lasting less than one scan must produce no event.
  task automatic run_bounce();
    int found;
    int pulses;
    wait_col(4'b0111, found);
    check_output("bounce_wait_col3", found, 1);
    wait_col(4'b1110, found);
    check_output("bounce_wait_col0", found, 1);
    pulses  = 0;
    pressed = 16'h0001;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      if (key_valid) pulses++;
    end
    pressed = 16'h0000;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      if (key_valid) pulses++;
    end
    check_output("bounce_pulses", pulses, 0);
    check_output("bounce_held", int'(key_held), 0);
  endtask

  initial begin
    int         pulses;
    int         latency;
    logic [3:0] one;
    logic [3:0] exp_col;

    checks  = 0;
    errors  = 0;
    pressed = 16'h0000;
    reset_n = 1'b0;
    one     = 4'b0001;

    phases[0] = '{16'h0000, 168, 0, 4'h0, 1'b0};
    phases[1] = '{16'h0200, 100, 1, 4'h9, 1'b1};
    phases[2] = '{16'h0000, 100, 0, 4'h9, 1'b0};
    phases[3] = '{16'h8001, 100, 0, 4'h9, 1'b0};
    phases[4] = '{16'h0001, 100, 1, 4'h0, 1'b1};
    phases[5] = '{16'h0000, 100, 0, 4'h0, 1'b0};
    phases[6] = '{16'h0040, 100, 1, 4'h6, 1'b1};
    phases[7] = '{16'h0440, 100, 0, 4'h6, 1'b1};
    phases[8] = '{16'h0000, 100, 0, 4'h6, 1'b0};
    phases[9] = '{16'h0040, 100, 1, 4'h6, 1'b1};

    // Reset values while reset is held.
    repeat (3) @(posedge clock);
    #1;
    check_output("reset_col", int'(col), 4'b1110);
    check_output("reset_code", int'(key_code), 0);
    check_output("reset_valid", int'(key_valid), 0);
    check_output("reset_held", int'(key_held), 0);

    // Column rotation: the column advances every SCAN_DIV edges after release.
    @(negedge clock);
    reset_n = 1'b1;
    pulses  = 0;
    for (int n = 1; n <= 2 * SCAN_CYCLES; n++) begin
      @(posedge clock);
      #1;
      if (key_valid) pulses++;
      exp_col = ~(one << ((n / SCAN_DIV) % 4));
      check_output($sformatf("rotate_col_n%0d", n), int'(col), int'(exp_col));
    end
    check_output("rotate_pulses", pulses, 0);

    for (int i = 0; i < 10; i++) begin
      if (i == 3) run_bounce();
      apply_stimulus(phases[i], i);
    end

    // Reset while held: outputs clear at once. The still-pressed key is
    // then re-accepted only after two full scans.
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_output("midreset_held", int'(key_held), 0);
    check_output("midreset_col", int'(col), 4'b1110);
    check_output("midreset_valid", int'(key_valid), 0);
    check_output("midreset_code", int'(key_code), 0);
    @(negedge clock);
    reset_n = 1'b1;
    latency = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock);
      #1;
      if (key_valid) begin
        latency = n;
        break;
      end
    end
    check_output("midreset_event_seen", int'(latency > 0), 1);
    check_output("midreset_min_latency", int'(latency >= DEBOUNCE_SCANS * SCAN_CYCLES), 1);
    check_output("midreset_max_latency", int'(latency <= 50), 1);
    check_output("midreset_event_code", int'(key_code), 6);
    check_output("midreset_event_held", int'(key_held), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
